// File: rtl/mux_rr_arbiter_pkg.sv
// Shared types and constants for the round-robin 4:1 mux arbiter.
package mux_rr_arbiter_pkg;
  typedef enum logic {
    ST_ARB  = 1'b0,
    ST_XFER = 1'b1
  } state_e;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;
endpackage

// File: rtl/mux_rr_arbiter_if.sv
// Requester/downstream bundle of the mux arbiter, plus FSM debug visibility.
interface mux_rr_arbiter_if #(
  parameter int MAX_BURST = 4
);
  import mux_rr_arbiter_pkg::*;
  localparam int CW = $clog2(MAX_BURST + 1);

  // Output handshake: a bit moves in any cycle with out_valid && out_ready;
  // while out_valid && !out_ready the owner holds req and data stable.
  logic [NUM_REQ-1:0] req;
  logic               in0, in1, in2, in3;
  logic               out_ready;
  logic               addr0, addr1;
  logic               out_valid;
  logic               out_data;
  logic [NUM_REQ-1:0] gnt;
  state_e             dbg_state;
  logic [SEL_W-1:0]   dbg_owner;
  logic [CW-1:0]      dbg_burst;

  modport slave (
    input  req, in0, in1, in2, in3, out_ready,
    output addr0, addr1, out_valid, out_data, gnt,
    output dbg_state, dbg_owner, dbg_burst
  );

  modport master (
    output req, in0, in1, in2, in3, out_ready,
    input  addr0, addr1, out_valid, out_data, gnt,
    input  dbg_state, dbg_owner, dbg_burst
  );
endinterface

// File: rtl/mux_rr_arbiter_rr_pick4.sv
// Rotating priority picker: first set req scanning base+1, base+2, base+3, base.
module rr_pick4
  import mux_rr_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   base,
  output logic               found,
  output logic [SEL_W-1:0]   idx
);
  logic [SEL_W-1:0] cand;

  // Walk from the farthest slot to the nearest so the nearest hit wins.
  always_comb begin
    found = 1'b0;
    idx   = base;
    cand  = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = base + SEL_W'(k);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end
endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter steering the structural 4:1 bit mux with bounded bursts.
module mux_rr_arbiter
  import mux_rr_arbiter_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          reset,
  mux_rr_arbiter_if.slave bus
);
  localparam int             CW        = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0]  BURST_MAX = CW'(MAX_BURST);

  state_e           state, state_nxt;
  logic [SEL_W-1:0] owner, owner_nxt;
  logic [SEL_W-1:0] sel;
  logic [CW-1:0]    burst_cnt, burst_nxt;
  logic             req_own;
  logic             keep;
  logic             found;
  logic [SEL_W-1:0] pick_idx;

  assign req_own = bus.req[owner];
  // burst_cnt is 0 in ARB only straight out of reset, when the owner has never
  // been granted; the scan then starts at in0 instead of re-serving owner 3.
  assign keep = req_own && (burst_cnt != '0) && (burst_cnt < BURST_MAX);

  rr_pick4 u_pick (
    .req   (bus.req),
    .base  (owner),
    .found (found),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_ARB;
      owner     <= SEL_W'(NUM_REQ - 1);
      burst_cnt <= '0;
      sel       <= '0;
    end else begin
      state     <= state_nxt;
      owner     <= owner_nxt;
      burst_cnt <= burst_nxt;
      if (state == ST_ARB && state_nxt == ST_XFER) sel <= owner_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    owner_nxt     = owner;
    burst_nxt     = burst_cnt;
    bus.out_valid = 1'b0;
    bus.gnt       = '0;
    case (state)
      ST_ARB: begin
        if (keep) begin
          state_nxt = ST_XFER;
        end else if (found) begin
          owner_nxt = pick_idx;
          burst_nxt = '0;
          state_nxt = ST_XFER;
        end
      end
      ST_XFER: begin
        bus.out_valid = req_own;
        if (!req_own) begin
          // Withdrawal: saturate the burst so the next ARB rotates away.
          burst_nxt = BURST_MAX;
          state_nxt = ST_ARB;
        end else if (bus.out_ready) begin
          bus.gnt   = NUM_REQ'(1) << owner;
          burst_nxt = burst_cnt + CW'(1);
          state_nxt = ST_ARB;
        end
      end
      default: state_nxt = ST_ARB;
    endcase
  end

  // Structural 4:1 single-bit multiplexer on the registered select.
  assign bus.out_data = (~sel[1] & ~sel[0] & bus.in0) |
                        (~sel[1] &  sel[0] & bus.in1) |
                        ( sel[1] & ~sel[0] & bus.in2) |
                        ( sel[1] &  sel[0] & bus.in3);

  assign bus.addr0     = sel[0];
  assign bus.addr1     = sel[1];
  assign bus.dbg_state = state;
  assign bus.dbg_owner = owner;
  assign bus.dbg_burst = burst_cnt;
endmodule
